// File: rtl/bp_cfg_boot_sequencer.sv
// Boot-time config sequencer: walks a synchronous config ROM and issues each {addr,data}
// entry as a config-bus write. It limits unacknowledged writes to max_outstanding_p and
// raises done_o once every write has been acknowledged.
// Optional feature: define BP_CFG_SEQ_TIMEOUT_EN to abort to ERROR when no ack or handshake
// arrives for timeout_p counted cycles while writes are outstanding.
module bp_cfg_boot_sequencer #(
  parameter int unsigned cfg_addr_width_p  = 16,
  parameter int unsigned cfg_data_width_p  = 64,
  parameter int unsigned num_entries_p     = 16,
  parameter int unsigned max_outstanding_p = 4,
  parameter int unsigned timeout_p         = 1024
) (
  input  logic                                         clk_i,
  input  logic                                         reset_n_i,
  input  logic                                         start_i,
  output logic                                         rom_v_o,
  output logic [$clog2(num_entries_p)-1:0]             rom_addr_o,
  input  logic [cfg_addr_width_p+cfg_data_width_p-1:0] rom_data_i,
  output logic                                         cfg_v_o,
  output logic [cfg_addr_width_p-1:0]                  cfg_addr_o,
  output logic [cfg_data_width_p-1:0]                  cfg_data_o,
  input  logic                                         cfg_ready_i,
  input  logic                                         cfg_ack_i,
  output logic                                         busy_o,
  output logic                                         done_o,
  output logic                                         error_o,
  output logic [$clog2(num_entries_p+1)-1:0]           count_o
);

  localparam int unsigned IdxW = $clog2(num_entries_p);
  localparam int unsigned CntW = $clog2(num_entries_p + 1);
  localparam int unsigned OutW = $clog2(max_outstanding_p + 1);

  if (num_entries_p < 2 || max_outstanding_p < 1 || timeout_p < 1) begin : g_param_check
    $error("bp_cfg_boot_sequencer: invalid parameter values");
  end

  typedef enum logic [2:0] {
    StIdle, StFetch, StCapture, StSend, StDrain, StDone, StError
  } state_e;

  state_e                      state_q, state_d;
  logic [IdxW-1:0]             idx_q, idx_d;
  logic [CntW-1:0]             count_q, count_d;
  logic [OutW-1:0]             out_q, out_d;
  logic [cfg_addr_width_p-1:0] addr_q, addr_d;
  logic [cfg_data_width_p-1:0] data_q, data_d;

  logic idle_like, send_v, hs, start_ok, spurious;

  // Credit is judged on the registered count, so a same-cycle ack never raises cfg_v_o.
  assign idle_like = (state_q == StIdle) || (state_q == StDone) || (state_q == StError);
  assign send_v    = (state_q == StSend) && (out_q < OutW'(max_outstanding_p));
  assign hs        = send_v & cfg_ready_i;
  assign start_ok  = start_i & idle_like;
  assign spurious  = cfg_ack_i & ~hs & (out_q == '0);

`ifdef BP_CFG_SEQ_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(timeout_p + 1);
  logic [TimerW-1:0] timer_q, timer_d;
`endif

  // Next-state, counters and hold register.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    out_d   = out_q;
    addr_d  = addr_q;
    data_d  = data_q;

    if (hs && !cfg_ack_i) begin
      out_d = out_q + OutW'(1);
    end else if (!hs && cfg_ack_i && out_q != '0) begin
      out_d = out_q - OutW'(1);
    end

    unique case (state_q)
      StFetch: state_d = StCapture;
      StCapture: begin
        addr_d  = rom_data_i[cfg_data_width_p +: cfg_addr_width_p];
        data_d  = rom_data_i[cfg_data_width_p-1:0];
        // All-ones address marks the end of the table; nothing is sent for it.
        state_d = (&rom_data_i[cfg_data_width_p +: cfg_addr_width_p]) ? StDrain : StSend;
      end
      StSend: begin
        if (hs) begin
          count_d = count_q + CntW'(1);
          idx_d   = idx_q + IdxW'(1);
          state_d = (idx_q == IdxW'(num_entries_p - 1)) ? StDrain : StFetch;
        end
      end
      StDrain: begin
        if (out_q == '0) state_d = StDone;
      end
      StIdle, StDone, StError: state_d = state_q;
      default: state_d = StIdle;
    endcase

`ifdef BP_CFG_SEQ_TIMEOUT_EN
    timer_d = timer_q;
    if (hs || cfg_ack_i) begin
      timer_d = '0;
    end else if ((state_q == StSend || state_q == StDrain) && out_q != '0) begin
      timer_d = timer_q + TimerW'(1);
      if (timer_q == TimerW'(timeout_p - 1)) state_d = StError;
    end
`endif

    if (spurious) state_d = StError;

    if (start_ok) begin
      state_d = StFetch;
      idx_d   = '0;
      count_d = '0;
      out_d   = '0;
`ifdef BP_CFG_SEQ_TIMEOUT_EN
      timer_d = '0;
`endif
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      count_q <= '0;
      out_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      out_q   <= out_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

`ifdef BP_CFG_SEQ_TIMEOUT_EN
  // Ack timeout counter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) timer_q <= '0;
    else            timer_q <= timer_d;
  end
`endif

  assign rom_v_o    = (state_q == StFetch);
  assign rom_addr_o = idx_q;
  assign cfg_v_o    = send_v;
  assign cfg_addr_o = addr_q;
  assign cfg_data_o = data_q;
  assign busy_o     = ~idle_like;
  assign done_o     = (state_q == StDone);
  assign error_o    = (state_q == StError);
  assign count_o    = count_q;

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// Self-checking bench for bp_cfg_boot_sequencer: table-driven sequences, randomized
// sequences against a transaction-level model, and hand-written corner cases.
module tb_bp_cfg_boot_sequencer;
  localparam int AW = 16;
  localparam int DW = 64;
  localparam int N  = 16;
  localparam int MO = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          start_i = 1'b0;
  logic          rom_v_o;
  logic [3:0]    rom_addr_o;
  logic [AW+DW-1:0] rom_data_i = '0;
  logic          cfg_v_o;
  logic [AW-1:0] cfg_addr_o;
  logic [DW-1:0] cfg_data_o;
  logic          cfg_ready_i = 1'b0;
  logic          cfg_ack_i = 1'b0;
  logic          busy_o, done_o, error_o;
  logic [4:0]    count_o;

  always #5 clk = ~clk;

  bp_cfg_boot_sequencer #(
    .cfg_addr_width_p(AW), .cfg_data_width_p(DW), .num_entries_p(N),
    .max_outstanding_p(MO), .timeout_p(TO)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .start_i(start_i), .rom_v_o(rom_v_o),
    .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i), .cfg_v_o(cfg_v_o),
    .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o), .cfg_ready_i(cfg_ready_i),
    .cfg_ack_i(cfg_ack_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .count_o(count_o)
  );

  // Reference model: the ROM image, the writes it must produce, and pending acks.
  logic [AW+DW-1:0] rom_mem [N];
  logic [AW+DW-1:0] exp_q [$];
  int ack_q [$];
  int cyc = 0, model_out = 0, hs_count = 0, rom_reads = 0;
  int first_v_cyc = -1, start_cyc = 0, last_hs_cyc = 0;
  int ready_pct = 100, ack_delay = 2;
  bit ack_hold = 0, prev_stall = 0, rom_pend = 0;
  logic [3:0]    rom_lat;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;
  int n_checks = 0, n_fail = 0;

  typedef struct {
    int n; int ready_pct; int ack_delay; int exp_count; bit exp_done;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
  endtask

  // One clock cycle: score the current cycle, advance, then drive the next inputs.
  task automatic run_cycle();
    bit hs;
    logic [AW+DW-1:0] e;
    hs = cfg_v_o && cfg_ready_i;
    if (prev_stall) begin
      check("hold_valid", 64'(cfg_v_o), 64'(1));
      check("hold_addr", 64'(cfg_addr_o), 64'(prev_addr));
      check("hold_data", cfg_data_o, prev_data);
    end
    if (cfg_v_o && first_v_cyc < 0) first_v_cyc = cyc;
    if (cfg_v_o) check("credit_limit", 64'(model_out < MO), 64'(1));
    if (hs) begin
      if (exp_q.size() == 0) fail_now("extra_write");
      else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(cfg_addr_o), 64'(e[AW+DW-1:DW]));
        check("wr_data", cfg_data_o, e[DW-1:0]);
      end
      hs_count++;
      model_out++;
      last_hs_cyc = cyc;
      ack_q.push_back(cyc + ack_delay);
    end
    if (cfg_ack_i && model_out > 0) model_out--;
    prev_stall = cfg_v_o && !cfg_ready_i;
    prev_addr  = cfg_addr_o;
    prev_data  = cfg_data_o;
    rom_pend   = rom_v_o;
    if (rom_v_o) begin
      rom_lat = rom_addr_o;
      rom_reads++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rom_pend) rom_data_i = rom_mem[rom_lat];
    start_i     = 1'b0;
    cfg_ready_i = (int'($urandom_range(99)) < ready_pct);
    cfg_ack_i   = 1'b0;
    if (!ack_hold && ack_q.size() > 0 && ack_q[0] <= cyc) begin
      void'(ack_q.pop_front());
      cfg_ack_i = 1'b1;
    end
  endtask

  task automatic inject_ack();
    cfg_ack_i = 1'b1;
    if (ack_q.size() > 0) void'(ack_q.pop_front());
  endtask

  // Random table; entry n gets the end marker when n < N.
  task automatic load_rom(input int n);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      a = AW'($urandom_range(32'hfffe));
      d = {$urandom(), $urandom()};
      if (i == n) a = '1;
      rom_mem[i] = {a, d};
      if (i < n) exp_q.push_back({a, d});
    end
  endtask

  task automatic pulse_start();
    start_i     = 1'b1;
    start_cyc   = cyc;
    first_v_cyc = -1;
    hs_count    = 0;
    rom_reads   = 0;
    run_cycle();
    model_out = 0;
    ack_q.delete();
    cfg_ack_i = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int k = 0;
    while (!(done_o || error_o) && k < budget) begin
      run_cycle();
      k++;
    end
    if (!(done_o || error_o)) fail_now("end_wait");
  endtask

  task automatic wait_hs(input int target);
    int k = 0;
    while (hs_count < target && k < 300) begin
      run_cycle();
      k++;
    end
    if (hs_count < target) fail_now("hs_wait");
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!cfg_v_o && k < 50) begin
      run_cycle();
      k++;
    end
    if (!cfg_v_o) fail_now("valid_wait");
  endtask

  task automatic run_seq(input int n, input int pct, input int dly, input int exp_count,
                         input bit exp_done);
    load_rom(n);
    ready_pct = pct;
    ack_delay = dly;
    ack_hold  = 0;
    pulse_start();
    wait_end(800);
    check("seq_done", 64'(done_o), 64'(exp_done));
    check("seq_error", 64'(error_o), 64'(0));
    check("seq_busy", 64'(busy_o), 64'(0));
    check("seq_count", 64'(count_o), 64'(exp_count));
    check("seq_all_written", 64'(exp_q.size()), 64'(0));
    check("seq_rom_reads", 64'(rom_reads), 64'((n < N) ? n + 1 : N));
    if (n > 0) check("seq_latency", 64'(first_v_cyc - start_cyc), 64'(3));
  endtask

  initial begin
    int n, a0, d0;
    logic [AW-1:0] snap_a;
    logic [DW-1:0] snap_d;

    vecs[0] = '{n: 3,  ready_pct: 100, ack_delay: 2, exp_count: 3,  exp_done: 1'b1};
    vecs[1] = '{n: 0,  ready_pct: 100, ack_delay: 1, exp_count: 0,  exp_done: 1'b1};
    vecs[2] = '{n: 16, ready_pct: 100, ack_delay: 1, exp_count: 16, exp_done: 1'b1};
    vecs[3] = '{n: 8,  ready_pct: 50,  ack_delay: 4, exp_count: 8,  exp_done: 1'b1};
    vecs[4] = '{n: 5,  ready_pct: 100, ack_delay: 8, exp_count: 5,  exp_done: 1'b1};
    vecs[5] = '{n: 1,  ready_pct: 20,  ack_delay: 1, exp_count: 1,  exp_done: 1'b1};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_rom_v", 64'(rom_v_o), 64'(0));
    check("rst_cfg_v", 64'(cfg_v_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    check("rst_error", 64'(error_o), 64'(0));
    check("rst_count", 64'(count_o), 64'(0));
    check("rst_addr", 64'(cfg_addr_o), 64'(0));
    reset_n_i = 1'b1;
    run_cycle();

    // Spurious ack in IDLE.
    cfg_ack_i = 1'b1;
    run_cycle();
    check("spurious_error", 64'(error_o), 64'(1));
    repeat (3) run_cycle();
    check("spurious_sticky", 64'(error_o), 64'(1));
    check("spurious_busy", 64'(busy_o), 64'(0));

    // Table-driven sequences.
    for (int i = 0; i < 6; i++) begin
      run_seq(vecs[i].n, vecs[i].ready_pct, vecs[i].ack_delay, vecs[i].exp_count,
              vecs[i].exp_done);
      if (i == 0) begin
        repeat (3) run_cycle();
        check("done_holds", 64'(done_o), 64'(1));
      end
    end

    // Randomized sequences.
    for (int i = 0; i < 8; i++) begin
      n = int'($urandom_range(N));
      a0 = int'($urandom_range(100, 30));
      d0 = int'($urandom_range(8, 1));
      run_seq(n, a0, d0, n, 1'b1);
    end

    // Credit limit with acks withheld.
    load_rom(8);
    ready_pct = 100;
    ack_delay = 1;
    ack_hold  = 1;
    pulse_start();
    wait_hs(4);
    repeat (10) run_cycle();
    check("credit_hs4", 64'(hs_count), 64'(4));
    check("credit_v_low", 64'(cfg_v_o), 64'(0));
    check("credit_busy", 64'(busy_o), 64'(1));
    inject_ack();
    repeat (8) run_cycle();
    check("credit_one_more", 64'(hs_count), 64'(5));
    check("credit_v_low2", 64'(cfg_v_o), 64'(0));
    ack_hold = 0;
    wait_end(400);
    check("credit_done", 64'(done_o), 64'(1));
    check("credit_count", 64'(count_o), 64'(8));
    check("credit_error", 64'(error_o), 64'(0));

    // Backpressure for 5 cycles mid-write; a start pulse while busy is ignored.
    load_rom(3);
    ready_pct = 100;
    ack_delay = 2;
    pulse_start();
    wait_hs(1);
    ready_pct   = 0;
    cfg_ready_i = 1'b0;
    wait_valid();
    snap_a = cfg_addr_o;
    snap_d = cfg_data_o;
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 64'(cfg_v_o), 64'(1));
      check("bp_addr", 64'(cfg_addr_o), 64'(snap_a));
      check("bp_data", cfg_data_o, snap_d);
      if (k == 2) start_i = 1'b1;
      run_cycle();
    end
    check("bp_no_hs", 64'(hs_count), 64'(1));
    ready_pct   = 100;
    cfg_ready_i = 1'b1;
    run_cycle();
    check("bp_single_hs", 64'(hs_count), 64'(2));
    wait_end(200);
    check("bp_done", 64'(done_o), 64'(1));
    check("bp_count", 64'(count_o), 64'(3));

    // Ack and handshake in the same cycle with one write outstanding.
    load_rom(3);
    ack_hold = 1;
    pulse_start();
    wait_hs(1);
    wait_valid();
    inject_ack();
    run_cycle();
    check("same_cycle_hs", 64'(hs_count), 64'(2));
    check("same_cycle_error", 64'(error_o), 64'(0));
    wait_hs(3);
    repeat (4) run_cycle();
    check("same_cycle_draining", 64'(busy_o), 64'(1));
    check("same_cycle_no_err", 64'(error_o), 64'(0));
    ack_hold = 0;
    wait_end(200);
    check("same_cycle_done", 64'(done_o), 64'(1));
    check("same_cycle_err_end", 64'(error_o), 64'(0));

    // Reset mid-SEND, then restart from entry 0.
    load_rom(3);
    ack_delay = 3;
    pulse_start();
    wait_hs(1);
    wait_valid();
    reset_n_i = 1'b0;
    #1;
    check("mid_rst_cfg_v", 64'(cfg_v_o), 64'(0));
    check("mid_rst_busy", 64'(busy_o), 64'(0));
    check("mid_rst_count", 64'(count_o), 64'(0));
    check("mid_rst_addr", 64'(cfg_addr_o), 64'(0));
    check("mid_rst_data", cfg_data_o, 64'(0));
    @(posedge clk);
    #1;
    cyc++;
    reset_n_i  = 1'b1;
    cfg_ack_i  = 1'b0;
    prev_stall = 0;
    model_out  = 0;
    ack_q.delete();
    run_seq(3, 100, 2, 3, 1'b1);

`ifdef BP_CFG_SEQ_TIMEOUT_EN
    // No acks: after the last handshake the FETCH/CAPTURE of the end marker are not
    // counted, so error_o appears TO+3 cycles after the handshake cycle.
    load_rom(3);
    ack_hold = 1;
    pulse_start();
    a0 = 0;
    while (!error_o && a0 < 200) begin
      run_cycle();
      a0++;
    end
    check("timeout_error", 64'(error_o), 64'(1));
    check("timeout_delay", 64'(cyc - last_hs_cyc), 64'(TO + 3));
    ack_hold = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
